// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, defaults and round-robin search for display arbiters
package display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_DWELL = 2_500_000;
  localparam int MAX_REQ       = 8;

  // Returns {found, index} of the first set bit of req strictly after 'last',
  // wrapping modulo n. The descending loop lets the nearest candidate win.
  function automatic logic [3:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [3:0] result;
    int idx;
    result = 4'b0000;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (req[idx[2:0]]) result = {1'b1, idx[2:0]};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/display_source_arbiter_if.sv
// rtl/display_source_arbiter_if.sv - requester/driver bundle for the display source arbiter
interface display_source_arbiter_if
  import display_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   grant;
  logic [2:0]         owner;
  logic               valid;
  logic [7:0]         disp_data;

  modport master (
    output req, data,
    input  grant, owner, valid, disp_data
  );

  modport slave (
    input  req, data,
    output grant, owner, valid, disp_data
  );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational wrap-around search from a start index
module rr_picker
  import display_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       start,
  output logic             found,
  output logic [2:0]       idx
);
  logic [7:0] req_ext;
  logic [2:0] last;
  logic [3:0] res;

  // rr_next searches after 'last', so step back one slot to include 'start'.
  always_comb begin
    req_ext = 8'(req);
    last    = (start == 3'd0) ? 3'(N_REQ - 1) : start - 3'd1;
    res     = rr_next(req_ext, last, N_REQ);
    found   = res[3];
    idx     = res[2:0];
  end
endmodule

// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - round-robin owner selection with minimum dwell for the hex display
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ        = DEFAULT_N_REQ,
  parameter int DWELL_CYCLES = DEFAULT_DWELL,
  parameter int CNT_W        = $clog2(DWELL_CYCLES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  display_source_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       last_owner;
  logic [N_REQ-1:0] grant_q;
  logic [2:0]       owner_q;
  logic             valid_q;
  logic [7:0]       data_q;

  logic [N_REQ-1:0] search_req;
  logic [N_REQ-1:0] pick_onehot;
  logic [2:0]       start;
  logic             found;
  logic [2:0]       pick;
  logic             owner_req;
  logic [7:0]       pick_data;
  logic [7:0]       owner_data;

  // grant_q is zero in IDLE, so masking it out only excludes the owner in HOLD.
  always_comb begin
    owner_req   = |(bus.req & grant_q);
    search_req  = bus.req & ~grant_q;
    start       = (last_owner == 3'(N_REQ - 1)) ? 3'd0 : last_owner + 3'd1;
    pick_data   = 8'h00;
    owner_data  = 8'h00;
    pick_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == 3'(k)) begin
        pick_data      = bus.data[8*k +: 8];
        pick_onehot[k] = 1'b1;
      end
      if (owner_q == 3'(k)) owner_data = bus.data[8*k +: 8];
    end
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req   (search_req),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 3'(N_REQ - 1);
      grant_q    <= '0;
      owner_q    <= 3'd0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_q    <= pick_onehot;
            owner_q    <= pick;
            valid_q    <= 1'b1;
            data_q     <= pick_data;
            cnt        <= '0;
            last_owner <= pick;
            state      <= HOLD;
          end else begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!owner_req) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            state   <= IDLE;
          end else if (cnt == DWELL_MAX && found) begin
            grant_q    <= pick_onehot;
            owner_q    <= pick;
            data_q     <= pick_data;
            cnt        <= '0;
            last_owner <= pick;
          end else begin
            data_q <= owner_data;
            if (cnt != DWELL_MAX) cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.valid     = valid_q;
  assign bus.disp_data = data_q;
endmodule

// File: tb/tb_display_source_arbiter.sv
// tb/tb_display_source_arbiter.sv - self-checking bench for display_source_arbiter
module tb_display_source_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;

  logic i_clk = 1'b0;
  logic i_resetn;
  always #5 i_clk = ~i_clk;

  display_source_arbiter_if #(.N_REQ(N)) bus ();

  display_source_arbiter #(
    .N_REQ        (N),
    .DWELL_CYCLES (DW)
  ) dut (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: owner index (-1 = nobody), cycles held, last granted index.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_last  = N - 1;
  logic [7:0] m_data  = 8'h00;

  typedef struct {
    logic        rn;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  g;
    logic        v;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [3:0] req, input int from);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] dt, input int k);
    return dt[8*k +: 8];
  endfunction

  task automatic model_update(input logic rn, input logic [3:0] rq, input logic [31:0] dt);
    int w;
    if (!rn) begin
      m_owner = -1; m_age = 0; m_last = N - 1; m_data = 8'h00;
    end else if (m_owner < 0) begin
      w = find(rq, m_last);
      if (w >= 0) begin
        m_owner = w; m_age = 0; m_last = w; m_data = byte_of(dt, w);
      end
    end else if (!rq[m_owner]) begin
      m_owner = -1;
    end else begin
      logic [3:0] others;
      others = rq;
      others[m_owner] = 1'b0;
      w = find(others, m_owner);
      if (m_age >= DW && w >= 0) begin
        m_owner = w; m_age = 0; m_last = w; m_data = byte_of(dt, w);
      end else begin
        m_age  = (m_age + 1 > DW) ? DW : m_age + 1;
        m_data = byte_of(dt, m_owner);
      end
    end
  endtask

  task automatic step(input logic rn, input logic [3:0] rq, input logic [31:0] dt);
    logic [3:0] eg;
    i_resetn = rn;
    bus.req  = rq;
    bus.data = dt;
    @(posedge i_clk);
    model_update(rn, rq, dt);
    @(negedge i_clk);
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("model_grant", 32'(bus.grant), 32'(eg));
    chk("model_valid", 32'(bus.valid), 32'(m_owner >= 0));
    chk("model_data", 32'(bus.disp_data), 32'(m_data));
    if (m_owner >= 0) chk("model_owner", 32'(bus.owner), 32'(m_owner));
    if (!rn) chk("reset_owner", 32'(bus.owner), 32'd0);
  endtask

  localparam logic [3:0] RR_ORDER [3] = '{4'b0001, 4'b0010, 4'b1000};

  initial begin
    i_resetn = 1'b0;
    bus.req  = '0;
    bus.data = '0;

    tbl[0] = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 4'b1111, 32'h44332211, 4'b0001, 1'b1, 8'h11};
    tbl[4] = '{1'b1, 4'b0100, 32'h443C2211, 4'b0000, 1'b0, 8'h11};
    tbl[5] = '{1'b1, 4'b0100, 32'h443C2211, 4'b0100, 1'b1, 8'h3C};
    tbl[6] = '{1'b1, 4'b0100, 32'h44A52211, 4'b0100, 1'b1, 8'hA5};
    for (int i = 7; i < 12; i++) tbl[i] = '{1'b1, 4'b0100, 32'h44A52211, 4'b0100, 1'b1, 8'hA5};
    tbl[12] = '{1'b1, 4'b0100, 32'h44A52299, 4'b0100, 1'b1, 8'hA5};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rn, tbl[i].req, tbl[i].data);
      chk("tbl_grant", 32'(bus.grant), 32'(tbl[i].g));
      chk("tbl_valid", 32'(bus.valid), 32'(tbl[i].v));
      chk("tbl_data", 32'(bus.disp_data), 32'(tbl[i].d));
      if (tbl[i].v) chk("tbl_owner", 32'(bus.owner), (tbl[i].g == 4'b0100) ? 32'd2 : 32'd0);
    end

    // Round-robin pre-emption: 0,1,3,0,1 each for exactly 5 cycles, never blank.
    step(1'b0, 4'b1011, $urandom);
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 4'b1011, $urandom);
      chk("rr_grant", 32'(bus.grant), 32'(RR_ORDER[(i / 5) % 3]));
      chk("rr_valid", 32'(bus.valid), 32'd1);
    end

    // Early release by owner 1 with requester 3 pending.
    step(1'b0, 4'b0000, $urandom);
    step(1'b1, 4'b0010, $urandom);
    chk("early_first", 32'(bus.grant), 32'b0010);
    step(1'b1, 4'b1010, $urandom);
    step(1'b1, 4'b1010, $urandom);
    chk("early_held", 32'(bus.grant), 32'b0010);
    step(1'b1, 4'b1000, $urandom);
    chk("early_blank", 32'(bus.valid), 32'd0);
    step(1'b1, 4'b1000, $urandom);
    chk("early_next", 32'(bus.grant), 32'b1000);

    // Release exactly on the expiry edge with requester 0 pending.
    step(1'b0, 4'b0000, $urandom);
    step(1'b1, 4'b0010, $urandom);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, $urandom);
    chk("expiry_held", 32'(bus.grant), 32'b0010);
    step(1'b1, 4'b0001, $urandom);
    chk("expiry_blank", 32'(bus.grant), 32'b0000);
    chk("expiry_blank_v", 32'(bus.valid), 32'd0);
    step(1'b1, 4'b0001, $urandom);
    chk("expiry_next", 32'(bus.grant), 32'b0001);

    // Reset during HOLD (owner 3, counter 2); the dwell must restart from zero.
    step(1'b0, 4'b0000, $urandom);
    step(1'b1, 4'b1000, $urandom);
    step(1'b1, 4'b1000, $urandom);
    step(1'b1, 4'b1000, $urandom);
    step(1'b0, 4'b1000, $urandom);
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_data", 32'(bus.disp_data), 32'd0);
    step(1'b1, 4'b1000, $urandom);
    chk("midrst_regrant", 32'(bus.grant), 32'b1000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b1001, $urandom);
      chk("midrst_dwell", 32'(bus.grant), 32'b1000);
    end
    step(1'b1, 4'b1001, $urandom);
    chk("midrst_switch", 32'(bus.grant), 32'b0001);

    // Randomized traffic against the reference.
    begin
      logic [3:0] rq;
      rq = 4'b0000;
      step(1'b0, rq, 32'h0);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(3) == 0) rq = 4'($urandom);
        step(($urandom_range(63) != 0), rq, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
